// File: rtl/matmul_fetch_scheduler.sv
// Fetch scheduler: walks every (A row, B col) pair, issues loader reads under FIFO credits and
// streams the returned pairs to the dot-product array. Optional tag check: FETCH_TAG_CHECK_EN.
module matmul_fetch_scheduler #(
   parameter int MAX_ELEMENT_SIZE = 8,
   parameter int MAX_SIZE_A       = 32,
   parameter int MAX_SIZE_B       = 32,
   parameter int READ_LATENCY     = 3,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic                                   inter_refclk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [$clog2(MAX_SIZE_A):0]            dim_a,
   input  logic [$clog2(MAX_SIZE_B):0]            dim_b,
   output logic [$clog2(MAX_SIZE_A)-1:0]          requested_a_row,
   output logic [$clog2(MAX_SIZE_B)-1:0]          requested_b_col,
   input  logic [MAX_SIZE_A*MAX_ELEMENT_SIZE-1:0] a_row_in,
   input  logic [MAX_SIZE_A*MAX_ELEMENT_SIZE-1:0] b_col_in,
   input  logic [$clog2(MAX_SIZE_A)-1:0]          a_addr_in,
   input  logic [$clog2(MAX_SIZE_B)-1:0]          b_addr_in,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [$clog2(MAX_SIZE_A)-1:0]          out_row_idx,
   output logic [$clog2(MAX_SIZE_B)-1:0]          out_col_idx,
   output logic [MAX_SIZE_A*MAX_ELEMENT_SIZE-1:0] out_a_row,
   output logic [MAX_SIZE_A*MAX_ELEMENT_SIZE-1:0] out_b_col,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   tag_error
);

   localparam int AW   = $clog2(MAX_SIZE_A);
   localparam int BW   = $clog2(MAX_SIZE_B);
   localparam int DW   = MAX_SIZE_A * MAX_ELEMENT_SIZE;
   localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW   = $clog2(FIFO_DEPTH + 1);
   localparam int TAIL = READ_LATENCY - 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

   if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_depth_check
      $error("FIFO_DEPTH must be >= READ_LATENCY+1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     row_q, row_d;
   logic [BW-1:0]     col_q, col_d;
   logic [AW:0]       dim_a_q, dim_a_d, last_row;
   logic [BW:0]       dim_b_q, dim_b_d, last_col;
   logic [READ_LATENCY-1:0] sr_valid_q, sr_valid_d;
   logic [AW-1:0]     sr_row_q [READ_LATENCY];
   logic [AW-1:0]     sr_row_d [READ_LATENCY];
   logic [BW-1:0]     sr_col_q [READ_LATENCY];
   logic [BW-1:0]     sr_col_d [READ_LATENCY];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d, inflight;
   logic [CW:0]       credits_used;
   logic              tag_error_q, tag_error_d;
   logic              fire, push, pop;

   logic [AW-1:0]     fifo_row_mem [FIFO_DEPTH];
   logic [BW-1:0]     fifo_col_mem [FIFO_DEPTH];
   logic [DW-1:0]     fifo_a_mem   [FIFO_DEPTH];
   logic [DW-1:0]     fifo_b_mem   [FIFO_DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A read holds its credit from issue until its entry is popped; a same-cycle pop does not count.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(sr_valid_q[i]);
      credits_used = {1'b0, inflight} + {1'b0, count_q};
      fire         = (state_q == S_ISSUE) && (credits_used < CREDITS);
      last_row     = dim_a_q - (AW+1)'(1);
      last_col     = dim_b_q - (BW+1)'(1);
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      dim_a_d = dim_a_q;
      dim_b_d = dim_b_q;
      case (state_q)
         S_IDLE: if (start) begin
            dim_a_d = dim_a;
            dim_b_d = dim_b;
            row_d   = '0;
            col_d   = '0;
            state_d = ((dim_a == '0) || (dim_b == '0)) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: if (fire) begin
            if ({1'b0, col_q} == last_col) begin
               col_d = '0;
               if ({1'b0, row_q} == last_row) state_d = S_DRAIN;
               else                           row_d   = row_q + AW'(1);
            end else begin
               col_d = col_q + BW'(1);
            end
         end
         S_DRAIN: if ((inflight == '0) && (count_q == '0)) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sr_valid_d    = '0;
      sr_valid_d[0] = fire;
      sr_row_d[0]   = row_q;
      sr_col_d[0]   = col_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
         sr_valid_d[i] = sr_valid_q[i-1];
         sr_row_d[i]   = sr_row_q[i-1];
         sr_col_d[i]   = sr_col_q[i-1];
      end
      push     = sr_valid_q[TAIL];
      pop      = out_valid && out_ready;
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

`ifdef FETCH_TAG_CHECK_EN
   assign tag_error_d = tag_error_q |
                        (push & ((a_addr_in != sr_row_q[TAIL]) | (b_addr_in != sr_col_q[TAIL])));
`else
   logic unused_tags;
   assign unused_tags = ^{a_addr_in, b_addr_in};
   assign tag_error_d = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge inter_refclk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         dim_a_q     <= '0;
         dim_b_q     <= '0;
         sr_valid_q  <= '0;
         sr_row_q    <= '{default: '0};
         sr_col_q    <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tag_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         dim_a_q     <= dim_a_d;
         dim_b_q     <= dim_b_d;
         sr_valid_q  <= sr_valid_d;
         sr_row_q    <= sr_row_d;
         sr_col_q    <= sr_col_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         tag_error_q <= tag_error_d;
      end
   end

   // NOTE: FIFO storage has no reset; count_q qualifies every read, so stale contents are never seen.
   always_ff @(posedge inter_refclk) begin
      if (push) begin
         fifo_row_mem[wr_ptr_q] <= sr_row_q[TAIL];
         fifo_col_mem[wr_ptr_q] <= sr_col_q[TAIL];
         fifo_a_mem[wr_ptr_q]   <= a_row_in;
         fifo_b_mem[wr_ptr_q]   <= b_col_in;
      end
   end

   a_no_overflow: assert property (@(posedge inter_refclk) disable iff (rst)
                                   !(push && (count_q == CW'(FIFO_DEPTH))));

   assign requested_a_row = row_q;
   assign requested_b_col = col_q;
   assign out_valid       = (count_q != '0);
   assign out_row_idx     = out_valid ? fifo_row_mem[rd_ptr_q] : '0;
   assign out_col_idx     = out_valid ? fifo_col_mem[rd_ptr_q] : '0;
   assign out_a_row       = out_valid ? fifo_a_mem[rd_ptr_q]   : '0;
   assign out_b_col       = out_valid ? fifo_b_mem[rd_ptr_q]   : '0;
   assign busy            = (state_q != S_IDLE);
   assign done            = (state_q == S_DONE);
   assign tag_error       = tag_error_q;

endmodule

// File: tb/tb_matmul_fetch_scheduler.sv
// Bench for matmul_fetch_scheduler: a fixed-latency loader model feeds random matrix rows/cols,
// and each job's transfers are checked against the row-major list of pairs it must produce.
module tb_matmul_fetch_scheduler;

   localparam int ES = 8, SA = 32, SB = 32, RL = 3, FD = 4;
   localparam int AW = $clog2(SA), BW = $clog2(SB), DW = SA * ES;
`ifdef FETCH_TAG_CHECK_EN
   localparam bit TAG_EXP = 1'b1;
`else
   localparam bit TAG_EXP = 1'b0;
`endif

   logic          inter_refclk = 1'b0;
   logic          rst, start, out_ready, corrupt_en;
   logic [AW:0]   dim_a;
   logic [BW:0]   dim_b;
   logic [AW-1:0] requested_a_row, a_addr_in, out_row_idx;
   logic [BW-1:0] requested_b_col, b_addr_in, out_col_idx;
   logic [DW-1:0] a_row_in, b_col_in, out_a_row, out_b_col;
   logic          out_valid, busy, done, tag_error;

   int n_tests, n_fail;

   always #5 inter_refclk = ~inter_refclk;

   matmul_fetch_scheduler #(
      .MAX_ELEMENT_SIZE(ES), .MAX_SIZE_A(SA), .MAX_SIZE_B(SB),
      .READ_LATENCY(RL), .FIFO_DEPTH(FD)
   ) dut (
      .inter_refclk(inter_refclk), .rst(rst), .start(start),
      .dim_a(dim_a), .dim_b(dim_b),
      .requested_a_row(requested_a_row), .requested_b_col(requested_b_col),
      .a_row_in(a_row_in), .b_col_in(b_col_in),
      .a_addr_in(a_addr_in), .b_addr_in(b_addr_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_row_idx(out_row_idx), .out_col_idx(out_col_idx),
      .out_a_row(out_a_row), .out_b_col(out_b_col),
      .busy(busy), .done(done), .tag_error(tag_error)
   );

   // Loader model: returns the stored row/col RL cycles after the address is presented.
   logic [DW-1:0] a_mem [SA];
   logic [DW-1:0] b_mem [SB];
   logic [AW-1:0] ld_a [RL];
   logic [BW-1:0] ld_b [RL];

   always @(posedge inter_refclk) begin
      ld_a[0] <= requested_a_row;
      ld_b[0] <= requested_b_col;
      for (int i = 1; i < RL; i++) begin
         ld_a[i] <= ld_a[i-1];
         ld_b[i] <= ld_b[i-1];
      end
   end

   assign a_row_in  = a_mem[ld_a[RL-1]];
   assign b_col_in  = b_mem[ld_b[RL-1]];
   assign a_addr_in = ld_a[RL-1];
   assign b_addr_in = (corrupt_en && ld_a[RL-1] == AW'(1) && ld_b[RL-1] == BW'(0))
                      ? (ld_b[RL-1] ^ BW'(1)) : ld_b[RL-1];

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One job: start it, play the consumer, and compare every transfer with the expected pair list.
   task automatic run_job(input int da, input int db, input int ready_pct, input int stall,
                          input int abort_at, input bit gapless, input bit poke);
      int exp_row[$];
      int exp_col[$];
      int cyc, n_xfer, last_xfer, first_valid, budget, er, ec;
      bit r, seen_done, hold;
      logic [AW-1:0] h_row;
      logic [BW-1:0] h_col;
      logic [DW-1:0] h_a, h_b;
      for (int i = 0; i < da; i++)
         for (int j = 0; j < db; j++) begin
            exp_row.push_back(i);
            exp_col.push_back(j);
         end
      budget = 100 + 20 * da * db + stall;
      dim_a  = (AW+1)'(da);
      dim_b  = (BW+1)'(db);
      start  = 1'b1;
      @(negedge inter_refclk);
      start = 1'b0;
      cyc = 0; n_xfer = 0; last_xfer = -2; first_valid = -1; seen_done = 0; hold = 0;
      while (!seen_done && cyc < budget) begin
         if (hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_row", out_row_idx, h_row);
            check("hold_col", out_col_idx, h_col);
            check("hold_a", out_a_row, h_a);
            check("hold_b", out_b_col, h_b);
         end
         if (out_valid && first_valid < 0) begin
            first_valid = cyc;
            check("first_valid_latency", cyc, 1 + RL);
         end
         if (done) begin
            seen_done = 1;
            start     = 1'b0;
            check("done_timing", cyc, last_xfer + 2);
            check("xfer_count", n_xfer, da * db);
            check("valid_at_done", out_valid, 0);
            check("busy_at_done", busy, 1);
         end else begin
            if (abort_at == n_xfer && out_valid) return;
            check("busy_running", busy, 1);
            if (stall > 0 && cyc == stall) begin
               check("stall_req_row", requested_a_row, FD / db);
               check("stall_req_col", requested_b_col, FD % db);
               check("stall_valid", out_valid, 1);
            end
            r = (cyc >= stall) && ($urandom_range(99) < ready_pct);
            out_ready = r;
            if (poke) begin
               start = ($urandom_range(3) == 0);
               dim_a = (AW+1)'($urandom_range(SA));
               dim_b = (BW+1)'($urandom_range(SB));
            end
            hold  = out_valid && !r;
            h_row = out_row_idx;
            h_col = out_col_idx;
            h_a   = out_a_row;
            h_b   = out_b_col;
            if (out_valid && r) begin
               if (exp_row.size() == 0) begin
                  check("extra_xfer", 1, 0);
               end else begin
                  er = exp_row.pop_front();
                  ec = exp_col.pop_front();
                  check("row", out_row_idx, er);
                  check("col", out_col_idx, ec);
                  check("a_data", out_a_row, a_mem[er]);
                  check("b_data", out_b_col, b_mem[ec]);
               end
               if (gapless && n_xfer > 0) check("gapless", cyc, last_xfer + 1);
               n_xfer++;
               last_xfer = cyc;
            end
            @(negedge inter_refclk);
            cyc++;
         end
      end
      start = 1'b0;
      if (!seen_done) check("done_timeout", 0, 1);
      @(negedge inter_refclk);
      check("idle_after_done", {busy, done, out_valid}, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_flags"}, {out_valid, busy, done, tag_error}, 0);
      check({tag, "_req"}, {requested_a_row, requested_b_col}, 0);
      check({tag, "_idx"}, {out_row_idx, out_col_idx}, 0);
      check({tag, "_a"}, out_a_row, 0);
      check({tag, "_b"}, out_b_col, 0);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < SA; i++)
         for (int k = 0; k < DW / 32; k++) a_mem[i][k*32 +: 32] = $urandom();
      for (int i = 0; i < SB; i++)
         for (int k = 0; k < DW / 32; k++) b_mem[i][k*32 +: 32] = $urandom();
      rst = 1'b1; start = 1'b0; dim_a = '0; dim_b = '0; out_ready = 1'b0; corrupt_en = 1'b0;
      repeat (2) @(negedge inter_refclk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge inter_refclk);

      run_job(2, 2, 100, 0, -1, 1, 0);
      run_job(0, 5, 100, 0, -1, 0, 0);
      run_job(3, 0, 100, 0, -1, 0, 0);
      run_job(3, 3, 100, 20, -1, 0, 0);
      run_job(32, 32, 100, 0, -1, 0, 0);
      run_job(1, 32, 60, 0, -1, 0, 0);
      repeat (12) run_job($urandom_range(7), $urandom_range(7), $urandom_range(100, 20), 0, -1, 0, 1);
      check("tag_clean", tag_error, 0);

      corrupt_en = 1'b1;
      run_job(2, 2, 100, 0, -1, 1, 0);
      corrupt_en = 1'b0;
      check("tag_set", tag_error, TAG_EXP);
      run_job(1, 3, 70, 0, -1, 0, 0);
      check("tag_held", tag_error, TAG_EXP);

      run_job(4, 8, 100, 0, 13, 0, 0);
      check("abort_pair", {out_row_idx, out_col_idx}, {AW'(1), BW'(5)});
      rst = 1'b1;
      #1;
      check_all_zero("mid_reset");
      @(negedge inter_refclk);
      rst = 1'b0;
      @(negedge inter_refclk);
      run_job(1, 1, 100, 0, -1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
